hazard_ctrl: RTL and testbench

Pipeline sequencer for the five-stage MIPS core: consumes the decoded control fields emerging from the ID/EX latch plus memory handshakes, and drives the enable/flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves load-use stalls, taken branch/jump squashes, instruction and data memory waits, and the halt drain sequence. It also keeps stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the five-stage core. Turns hazard
// conditions into latch enables and flushes, and runs the halt drain.
// It also keeps saturating stall and squash counters.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             idex_dMemREN,
    input  logic             idex_regWEN,
    input  logic [4:0]       idex_wsel,
    input  logic             idex_Halt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             exmem_dMemREN,
    input  logic             exmem_dMemWEN,
    input  logic             br_taken,
    input  logic             jump,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DWAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    // Drain counter must hold DRAIN_CYCLES; keep at least one bit.
    localparam int unsigned DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             pend_q, pend_d;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic dwait;
    logic load_use;
    logic squash_act;

    assign dwait    = (exmem_dMemREN | exmem_dMemWEN) & ~dhit;
    assign load_use = idex_dMemREN & idex_regWEN & (idex_wsel != 5'd0) &
                      ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Latch enables/flushes by priority: reset, halted, dwait, drain, load-use, squash, ifetch.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        squash_act  = 1'b0;
        if (!RST && state_q != S_HALTED) begin
            if (dwait) begin
                // Freeze everything; MEM/WB takes a bubble so WB does not repeat.
                memwb_en    = 1'b1;
                memwb_flush = 1'b1;
            end else if (state_q == S_DRAIN) begin
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                idex_flush = 1'b1;
            end else if (br_taken | jump) begin
                // Target is loaded even if the current fetch has not completed.
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                squash_act = 1'b1;
            end else if (!ihit) begin
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // Sequencer next state: data waits, pending halt and drain countdown.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pend_d  = pend_q;
        case (state_q)
            S_RUN, S_DWAIT: begin
                if (dwait) begin
                    state_d = S_DWAIT;
                    if (idex_Halt) pend_d = 1'b1;
                end else if (pend_q || idex_Halt) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_INIT;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // A data wait freezes the drain countdown.
                if (!dwait) begin
                    if (drain_q == '0) state_d = S_HALTED;
                    else drain_d = drain_q - DCW'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State, halted flag and counters with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_RUN;
            drain_q     <= '0;
            pend_q      <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            pend_q   <= pend_d;
            halted_q <= (state_d == S_HALTED);
            if (!pc_en && state_q != S_HALTED && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (squash_act && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan steps followed by random stimulus,
// all checked every cycle against a behavioural model of the sequencer.
module tb_hazard_ctrl;

    localparam int DRAIN = 2;
    localparam int W     = 6;
    localparam int MAXC  = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         RST;
    logic         ihit, dhit;
    logic         idex_dMemREN, idex_regWEN, idex_Halt;
    logic [4:0]   idex_wsel, ifid_rs, ifid_rt;
    logic         ifid_uses_rt;
    logic         exmem_dMemREN, exmem_dMemWEN;
    logic         br_taken, jump;
    logic         pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic         ifid_flush, idex_flush, memwb_flush;
    logic         halted;
    logic [W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .idex_dMemREN(idex_dMemREN), .idex_regWEN(idex_regWEN), .idex_wsel(idex_wsel),
        .idex_Halt(idex_Halt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .exmem_dMemREN(exmem_dMemREN),
        .exmem_dMemWEN(exmem_dMemWEN), .br_taken(br_taken), .jump(jump),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .halted(halted), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush}
    wire [7:0] obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, memwb_flush};

    localparam logic [7:0] O_NORM   = 8'b11111_000;
    localparam logic [7:0] O_OFF    = 8'b00000_000;
    localparam logic [7:0] O_DWAIT  = 8'b00001_001;
    localparam logic [7:0] O_LUSE   = 8'b00111_010;
    localparam logic [7:0] O_SQUASH = 8'b11111_110;
    localparam logic [7:0] O_IWAIT  = 8'b01111_100;
    localparam logic [7:0] O_DRAIN  = 8'b01111_110;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: halted flag, drain edges left, data-wait and pending-halt flags.
    bit   m_halted, m_drain, m_wait, m_pend;
    int   m_left, m_stall, m_flush;
    logic [7:0] s_obs;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    function automatic bit dw_f();
        return (exmem_dMemREN || exmem_dMemWEN) && !dhit;
    endfunction

    function automatic bit hz_f();
        return idex_dMemREN && idex_regWEN && idex_wsel != 0 &&
               (idex_wsel == ifid_rs || (ifid_uses_rt && idex_wsel == ifid_rt));
    endfunction

    function automatic logic [7:0] exp_out();
        if (RST || m_halted) return O_OFF;
        if (dw_f())          return O_DWAIT;
        if (m_drain)         return O_DRAIN;
        if (hz_f())          return O_LUSE;
        if (br_taken || jump) return O_SQUASH;
        if (!ihit)           return O_IWAIT;
        return O_NORM;
    endfunction

    task automatic model_edge(input logic [7:0] e);
        if (RST) begin
            m_halted = 0; m_drain = 0; m_wait = 0; m_pend = 0;
            m_left = 0; m_stall = 0; m_flush = 0;
        end else if (!m_halted) begin
            if (!e[7] && m_stall < MAXC) m_stall++;
            if (!m_drain && !dw_f() && !hz_f() && (br_taken || jump) && m_flush < MAXC)
                m_flush++;
            if (m_drain) begin
                if (!dw_f()) begin
                    if (m_left == 0) begin m_halted = 1; m_drain = 0; end
                    else m_left--;
                end
            end else if (dw_f()) begin
                m_wait = 1;
                if (idex_Halt) m_pend = 1;
            end else begin
                m_wait = 0;
                if (m_pend || idex_Halt) begin
                    m_drain = 1; m_left = DRAIN; m_pend = 0;
                end
            end
        end
    endtask

    // One clock: check enables mid-cycle, advance model, check registered outputs.
    task automatic step(input string tag);
        logic [7:0] e;
        @(negedge CLK);
        e = exp_out();
        s_obs = obs;
        chk({tag, ":outs"}, {24'b0, obs}, {24'b0, e});
        @(posedge CLK);
        model_edge(e);
        #1;
        chk({tag, ":halted"}, {31'b0, halted}, {31'b0, m_halted});
        chk({tag, ":stall"}, {26'b0, stall_cnt}, m_stall);
        chk({tag, ":flush"}, {26'b0, flush_cnt}, m_flush);
    endtask

    task automatic idle();
        RST = 0; ihit = 1; dhit = 0;
        idex_dMemREN = 0; idex_regWEN = 0; idex_wsel = 0; idex_Halt = 0;
        ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
        exmem_dMemREN = 0; exmem_dMemWEN = 0; br_taken = 0; jump = 0;
    endtask

    task automatic do_reset();
        idle(); RST = 1;
        step("reset");
        RST = 0;
    endtask

    initial begin
        idle(); RST = 1;
        #1;
        step("rst0");
        chk("rst_outs", {24'b0, s_obs}, {24'b0, O_OFF});
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_stall", {26'b0, stall_cnt}, 0);
        RST = 0;

        // Load-use on rs: one-cycle stall, then normal.
        idle(); idex_dMemREN = 1; idex_regWEN = 1; idex_wsel = 5; ifid_rs = 5;
        step("luse");
        chk("luse_outs", {24'b0, s_obs}, {24'b0, O_LUSE});
        idle();
        step("luse_after");
        chk("luse_after_outs", {24'b0, s_obs}, {24'b0, O_NORM});
        chk("luse_stall", {26'b0, stall_cnt}, 1);

        // No stall: wsel=0, and rt-only match without rt use.
        idle(); idex_dMemREN = 1; idex_regWEN = 1; idex_wsel = 0; ifid_rs = 0;
        step("luse_r0");
        chk("luse_r0_outs", {24'b0, s_obs}, {24'b0, O_NORM});
        idle(); idex_dMemREN = 1; idex_regWEN = 1; idex_wsel = 7; ifid_rs = 3; ifid_rt = 7;
        step("luse_nort");
        chk("luse_nort_outs", {24'b0, s_obs}, {24'b0, O_NORM});
        ifid_uses_rt = 1;
        step("luse_rt");
        chk("luse_rt_outs", {24'b0, s_obs}, {24'b0, O_LUSE});

        // Taken branch while fetch is stalled.
        do_reset();
        idle(); br_taken = 1; ihit = 0;
        step("squash");
        chk("squash_outs", {24'b0, s_obs}, {24'b0, O_SQUASH});
        chk("squash_cnt", {26'b0, flush_cnt}, 1);

        // Three data-wait cycles then hit.
        do_reset();
        idle(); exmem_dMemREN = 1;
        for (int i = 0; i < 3; i++) begin
            step("dwait");
            chk("dwait_outs", {24'b0, s_obs}, {24'b0, O_DWAIT});
        end
        dhit = 1;
        step("dhit");
        chk("dhit_outs", {24'b0, s_obs}, {24'b0, O_NORM});
        chk("dwait_stall", {26'b0, stall_cnt}, 3);

        // Halt with one data-wait cycle during drain.
        do_reset();
        idle(); idex_Halt = 1;
        step("halt0");
        idle(); exmem_dMemREN = 1;
        step("halt_dw");
        idle();
        step("halt_e2");
        step("halt_e3");
        chk("halt_early", {31'b0, halted}, 0);
        step("halt_e4");
        chk("halt_set", {31'b0, halted}, 1);
        br_taken = 1; ihit = 0; idex_dMemREN = 1; idex_regWEN = 1; idex_wsel = 1; ifid_rs = 1;
        step("halted_hold");
        chk("halted_outs", {24'b0, s_obs}, {24'b0, O_OFF});
        idle(); RST = 1;
        step("halted_rst");
        chk("hrst_halted", {31'b0, halted}, 0);
        chk("hrst_stall", {26'b0, stall_cnt}, 0);
        chk("hrst_flush", {26'b0, flush_cnt}, 0);

        // Reset in the middle of a drain.
        idle(); idex_Halt = 1;
        step("drn_h");
        idle();
        step("drn_1");
        chk("drn_outs", {24'b0, s_obs}, {24'b0, O_DRAIN});
        RST = 1;
        step("drn_rst");
        chk("drn_rst_stall", {26'b0, stall_cnt}, 0);
        idle();
        step("drn_run");
        chk("drn_run_outs", {24'b0, s_obs}, {24'b0, O_NORM});

        // Counter saturation.
        do_reset();
        idle(); ihit = 0;
        for (int i = 0; i < MAXC + 6; i++) step("sat_stall");
        chk("sat_stall_val", {26'b0, stall_cnt}, MAXC);
        idle(); jump = 1;
        for (int i = 0; i < MAXC + 6; i++) step("sat_flush");
        chk("sat_flush_val", {26'b0, flush_cnt}, MAXC);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            RST           = ($urandom_range(0, 59) == 0) ||
                            (m_halted && $urandom_range(0, 7) == 0);
            ihit          = ($urandom_range(0, 3) != 0);
            dhit          = 1'($urandom_range(0, 1));
            exmem_dMemREN = ($urandom_range(0, 3) == 0);
            exmem_dMemWEN = ($urandom_range(0, 5) == 0);
            idex_dMemREN  = ($urandom_range(0, 2) == 0);
            idex_regWEN   = 1'($urandom_range(0, 1));
            idex_wsel     = 5'($urandom_range(0, 3));
            ifid_rs       = 5'($urandom_range(0, 3));
            ifid_rt       = 5'($urandom_range(0, 3));
            ifid_uses_rt  = 1'($urandom_range(0, 1));
            idex_Halt     = ($urandom_range(0, 29) == 0);
            br_taken      = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
